// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, default
// parameter values and the counter width helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_NUM_OUT     = 3;
    localparam int DEF_STAGE_GAP   = 4;

    // Wide enough to hold the larger of the hold count and the stage gap.
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int top;
        top = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer of SYNC_STAGES flops.
// sync_pre_n is the D input of the last flop (one edge ahead of sync_rst_n).
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n,
    output logic sync_pre_n
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = chain_q[SYNC_STAGES-1];
    assign sync_pre_n = chain_q[SYNC_STAGES-2];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes Rst_n, holds for HOLD_CYCLES, then releases
// Rst_out_n bits in index order STAGE_GAP apart. Option RST_SEQ_SW_RST_EN adds Sw_rst_req.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int NUM_OUT     = DEF_NUM_OUT,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic               Clk,
    input  logic               Rst_n,
`ifdef RST_SEQ_SW_RST_EN
    input  logic               Sw_rst_req,
`endif
    output logic [NUM_OUT-1:0] Rst_out_n,
    output logic               Rst_done
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    logic               sync_rst_n;
    logic               sync_pre_n;
    logic               hold_run;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               done_q, done_d;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .sync_rst_n(sync_rst_n),
        .sync_pre_n(sync_pre_n)
    );

    // The hold window opens on the edge where sync_rst_n rises, so that
    // HOLD_CYCLES=0 releases bit 0 on that same edge.
    assign hold_run = sync_pre_n | sync_rst_n;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_HOLD: begin
                if (hold_run) begin
                    if (cnt_q == HOLD_LAST) begin
                        out_d[0] = 1'b1;
                        cnt_d    = '0;
                        idx_d    = IDX_W'(1);
                        state_d  = (NUM_OUT == 1) ? ST_DONE : ST_STAGE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_STAGE: begin
                if (cnt_q == GAP_LAST) begin
                    // Shift in a one: released bits stay released, order is by index.
                    out_d = (out_q << 1) | NUM_OUT'(1);
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
`ifdef RST_SEQ_SW_RST_EN
                // Synchronizer stays released, so re-release is HOLD_CYCLES+1 edges out.
                if (Sw_rst_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    out_d   = '0;
                    done_d  = 1'b0;
                end
`endif
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign Rst_out_n = out_q;
    assign Rst_done  = done_q;

endmodule
